// File: rtl/bus_refill_if.sv
// Cache-refill bus bundle: the cache-side miss request and fill port plus the
// byte-wide external memory read port, grouped so the refill engine and its
// environment share one connection.
interface bus_refill_if;
  // Cache miss request
  logic        miss;
  logic [15:0] miss_addr;
  logic        busy;

  // External byte-wide memory read port
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;

  // Cache line fill port
  logic        fill_we;
  logic [15:0] fill_addr;
  logic [7:0]  fill_data;
  logic        fill_done;
  logic        fill_err;

  // View of the refill engine itself
  modport slave (
    input  miss, miss_addr, mem_ack, mem_data,
    output busy, mem_req, mem_addr,
    output fill_we, fill_addr, fill_data, fill_done, fill_err
  );

  // View of the environment (cache + memory) driving the engine
  modport master (
    output miss, miss_addr, mem_ack, mem_data,
    input  busy, mem_req, mem_addr,
    input  fill_we, fill_addr, fill_data, fill_done, fill_err
  );
endinterface

// File: rtl/bus_refill.sv
// Cache-miss refill engine. Fetches one aligned line of LINE_BYTES bytes from
// byte-wide memory, critical byte first with wrap-around inside the line,
// writing each byte into the cache with a one-cycle strobe. A refill ends with
// a one-cycle fill_done pulse, or with a one-cycle fill_err pulse if memory
// fails to acknowledge within TIMEOUT cycles.
module bus_refill #(
  parameter int LINE_BYTES = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  bus_refill_if.slave bus
);

  localparam int IDXW = $clog2(LINE_BYTES);
  localparam int UPW  = 16 - IDXW;

  // Index of the final byte of a line, and the timeout counter value at which
  // one more unacknowledged request cycle exhausts the budget.
  localparam logic [IDXW-1:0] LAST_COUNT = IDXW'(LINE_BYTES - 1);
  localparam logic [7:0]      TMO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg;

  // Line context: upper address bits are fixed for the whole refill, only the
  // in-line index moves (modulo LINE_BYTES by virtue of its width).
  logic [UPW-1:0]  upper_reg;
  logic [IDXW-1:0] idx_reg;
  logic [IDXW-1:0] count_reg;
  logic [7:0]      tmo_reg;

  // Registered outputs
  logic            mem_req_reg;
  logic [15:0]     mem_addr_reg;
  logic            fill_we_reg;
  logic [15:0]     fill_addr_reg;
  logic [7:0]      fill_data_reg;
  logic            fill_done_reg;
  logic            fill_err_reg;

  logic [IDXW-1:0] idx_next;

  assign idx_next = idx_reg + IDXW'(1);

  // Refill FSM: sequencing, address generation and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      upper_reg     <= '0;
      idx_reg       <= '0;
      count_reg     <= '0;
      tmo_reg       <= '0;
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      fill_we_reg   <= 1'b0;
      fill_addr_reg <= '0;
      fill_data_reg <= '0;
      fill_done_reg <= 1'b0;
      fill_err_reg  <= 1'b0;
    end else begin
      // Strobes and pulses last exactly one cycle unless re-asserted below.
      fill_we_reg   <= 1'b0;
      fill_done_reg <= 1'b0;
      fill_err_reg  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (bus.miss) begin
            upper_reg    <= bus.miss_addr[15:IDXW];
            idx_reg      <= bus.miss_addr[IDXW-1:0];
            count_reg    <= '0;
            tmo_reg      <= '0;
            mem_req_reg  <= 1'b1;
            // Missed byte goes out first; base|idx equals the miss address.
            mem_addr_reg <= bus.miss_addr;
            state_reg    <= REQ;
          end
        end

        REQ: begin
          if (bus.mem_ack) begin
            // Data is valid with the acknowledge; present it next cycle.
            fill_data_reg <= bus.mem_data;
            fill_addr_reg <= {upper_reg, idx_reg};
            fill_we_reg   <= 1'b1;
            mem_req_reg   <= 1'b0;
            state_reg     <= WRITE;
          end else if (tmo_reg == TMO_LAST) begin
            // Budget exhausted: abandon the line rather than hang the core.
            tmo_reg      <= tmo_reg + 8'd1;
            mem_req_reg  <= 1'b0;
            fill_err_reg <= 1'b1;
            state_reg    <= IDLE;
          end else begin
            tmo_reg <= tmo_reg + 8'd1;
          end
        end

        WRITE: begin
          if (count_reg == LAST_COUNT) begin
            fill_done_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg      <= idx_next;
            count_reg    <= count_reg + IDXW'(1);
            tmo_reg      <= '0;
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= {upper_reg, idx_next};
            state_reg    <= REQ;
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (state_reg != IDLE);
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.fill_we   = fill_we_reg;
  assign bus.fill_addr = fill_addr_reg;
  assign bus.fill_data = fill_data_reg;
  assign bus.fill_done = fill_done_reg;
  assign bus.fill_err  = fill_err_reg;

endmodule

// File: tb/tb_bus_refill.sv
// Bench for bus_refill: drives miss requests and a latency-programmable byte
// memory, collects the fill writes and pulses, and compares them with a
// line-level model (expected write order, per-byte cost 2+W, timeout cost).
module tb_bus_refill;

  localparam int LB  = 4;
  localparam int TMO = 15;
  localparam int NEVER = 255;  // wait value meaning "never acknowledge"

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bus_refill_if bus ();

  bus_refill #(
    .LINE_BYTES(LB),
    .TIMEOUT   (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Per-byte acknowledge latency for the next refill, in request order.
  int wait_tab[LB];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One miss from sampling through the first idle cycle, plus a quiet tail.
  task automatic run_refill(input string name, input logic [15:0] addr,
                            input logic [7:0] key, input int rst_after,
                            input bit poke_miss);
    logic [15:0] exp_addr[LB];
    logic [15:0] w_addr[16];
    logic [7:0]  w_data[16];
    logic [15:0] seen_addr[LB];
    logic [15:0] cur_addr;
    logic [15:0] base;
    int idx0, abort_at, t, exp_req, exp_end;
    int cyc, nw, nb, n_done, n_err, done_cyc, err_cyc, n_req, req_wait;
    int viol, unstable, quiet;
    bit finished, rst_fired, rst_pending;

    // Line-level expectation
    base  = addr & ~16'(LB - 1);
    idx0  = int'(addr) % LB;
    for (int k = 0; k < LB; k++) exp_addr[k] = base + 16'((idx0 + k) % LB);
    abort_at = LB;
    for (int k = LB - 1; k >= 0; k--) if (wait_tab[k] >= TMO) abort_at = k;
    t = 0;
    exp_req = 0;
    for (int k = 0; k < abort_at; k++) begin
      t += 2 + wait_tab[k];
      exp_req += wait_tab[k] + 1;
    end
    if (abort_at < LB) begin
      exp_req += TMO;
      exp_end = t + TMO + 1;   // error pulse lands in the first idle cycle
    end else begin
      exp_end = t + 2;         // done pulse at t+1, idle at t+2
    end

    cyc = 0; nw = 0; nb = 0; n_done = 0; n_err = 0; done_cyc = -1; err_cyc = -1;
    n_req = 0; req_wait = 0; viol = 0; unstable = 0; cur_addr = '0;
    finished = 0; rst_fired = 0; rst_pending = 0;

    bus.miss      = 1'b1;
    bus.miss_addr = addr;

    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (rst_pending) begin
        check({name, "_rst_ctrl"},
              {19'd0, bus.fill_data, bus.busy, bus.mem_req, bus.fill_we, bus.fill_done, bus.fill_err}, 32'd0);
        check({name, "_rst_addr"}, {bus.mem_addr, bus.fill_addr}, 32'd0);
        rst = 1'b0;
        rst_pending = 0;
      end
      if (cyc == 1) check({name, "_busy_rise"}, 32'(bus.busy), 32'd1);
      if (bus.fill_we) begin
        if (nw < 16) begin
          w_addr[nw] = bus.fill_addr;
          w_data[nw] = bus.fill_data;
        end
        nw++;
        if (bus.mem_req) viol++;
      end
      if (bus.fill_done) begin n_done++; done_cyc = cyc; end
      if (bus.fill_err) begin
        n_err++; err_cyc = cyc;
        if (bus.mem_req) viol++;
      end
      if (bus.fill_done && bus.fill_err) viol++;

      // Cache side: optional stray misses while busy, otherwise quiet.
      bus.miss      = (poke_miss && bus.busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.miss_addr = 16'($urandom);

      // Memory side
      if (bus.mem_req) begin
        n_req++;
        if (req_wait == 0) cur_addr = bus.mem_addr;
        else if (bus.mem_addr != cur_addr) unstable++;
        if (nb < LB && req_wait == wait_tab[nb]) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = bus.mem_addr[7:0] ^ key;
          seen_addr[nb] = bus.mem_addr;
          nb++;
          req_wait = 0;
        end else begin
          bus.mem_ack  = 1'b0;
          bus.mem_data = 8'($urandom);
          req_wait++;
        end
      end else begin
        bus.mem_ack  = 1'($urandom_range(0, 1));  // must be ignored
        bus.mem_data = 8'($urandom);
      end

      if (rst_after > 0 && nw == rst_after && !rst_fired) begin
        rst = 1'b1;
        rst_fired = 1;
        rst_pending = 1;
      end
      if (!bus.busy && !rst_pending) finished = 1;
    end
    check({name, "_bounded"}, 32'(finished), 32'd1);

    // Quiet tail: no restarted refill, no late pulses.
    bus.miss = 1'b0;
    quiet = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.busy || bus.mem_req || bus.fill_we || bus.fill_done || bus.fill_err) quiet++;
      bus.mem_ack = 1'($urandom_range(0, 1));
    end
    bus.mem_ack = 1'b0;
    check({name, "_quiet"}, 32'(quiet), 32'd0);

    if (rst_after > 0) begin
      check({name, "_rst_writes"}, 32'(nw), 32'(rst_after));
      check({name, "_rst_pulses"}, 32'(n_done + n_err), 32'd0);
    end else begin
      check({name, "_writes"}, 32'(nw), 32'(abort_at));
      for (int k = 0; k < nw && k < abort_at && k < 16; k++)
        check($sformatf("%s_wr%0d", name, k), {8'd0, w_addr[k], w_data[k]},
              {8'd0, exp_addr[k], exp_addr[k][7:0] ^ key});
      check({name, "_acks"}, 32'(nb), 32'(abort_at));
      for (int k = 0; k < nb && k < abort_at; k++)
        check($sformatf("%s_maddr%0d", name, k), 32'(seen_addr[k]), 32'(exp_addr[k]));
      check({name, "_req_cycles"}, 32'(n_req), 32'(exp_req));
      check({name, "_end_cycle"}, 32'(cyc), 32'(exp_end));
      if (abort_at < LB) begin
        check({name, "_err_cnt"}, 32'(n_err), 32'd1);
        check({name, "_err_cycle"}, 32'(err_cyc), 32'(exp_end));
        check({name, "_done_cnt"}, 32'(n_done), 32'd0);
      end else begin
        check({name, "_done_cnt"}, 32'(n_done), 32'd1);
        check({name, "_done_cycle"}, 32'(done_cyc), 32'(exp_end - 1));
        check({name, "_err_cnt"}, 32'(n_err), 32'd0);
      end
    end
    check({name, "_overlap"}, 32'(viol), 32'd0);
    check({name, "_addr_stable"}, 32'(unstable), 32'd0);
    $display("refill %s addr=0x%04h cycles=%0d writes=%0d done=%0d err=%0d", name, addr, cyc, nw, n_done, n_err);
  endtask

  task automatic set_waits(input int w);
    for (int k = 0; k < LB; k++) wait_tab[k] = w;
  endtask

  initial begin
    rst           = 1'b1;
    bus.miss      = 1'b1;
    bus.miss_addr = 16'h1234;
    bus.mem_ack   = 1'b0;
    bus.mem_data  = 8'h00;

    // Reset held two cycles with miss asserted: everything stays low.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("reset_ctrl%0d", i),
            {19'd0, bus.fill_data, bus.busy, bus.mem_req, bus.fill_we, bus.fill_done, bus.fill_err}, 32'd0);
      check($sformatf("reset_addr%0d", i), {bus.mem_addr, bus.fill_addr}, 32'd0);
    end
    rst = 1'b0;
    bus.miss = 1'b0;
    @(negedge clk);
    check("reset_idle", {30'd0, bus.busy, bus.mem_req}, 32'd0);
    $display("reset checked");

    set_waits(0);
    run_refill("aligned", 16'h1230, 8'hA5, 0, 0);

    set_waits(0);
    run_refill("wrap", 16'h12FE, 8'($urandom), 0, 0);

    set_waits(3);
    run_refill("wait3", 16'($urandom), 8'($urandom), 0, 0);

    set_waits(NEVER);
    run_refill("timeout", 16'($urandom), 8'($urandom), 0, 0);

    set_waits(1);
    wait_tab[2] = TMO - 1;
    run_refill("wait_edge", 16'($urandom), 8'($urandom), 0, 0);

    set_waits(0);
    run_refill("mid_reset", 16'($urandom), 8'($urandom), 2, 0);

    set_waits(1);
    run_refill("overlap", 16'($urandom), 8'($urandom), 0, 1);

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < LB; k++) wait_tab[k] = $urandom_range(0, 4);
      if ($urandom_range(0, 5) == 0) wait_tab[$urandom_range(0, LB - 1)] = NEVER;
      run_refill($sformatf("rand%0d", r), 16'($urandom), 8'($urandom), 0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_refill.md
# bus_refill

Cache-miss refill engine between the instruction/data cache and external byte-wide memory. On a miss it fetches one aligned cache line, one byte per request/acknowledge transaction, starting with the missed byte and wrapping within the line. Each byte is written into the cache through a single-cycle write strobe, and completion is signalled with a one-cycle done pulse. An acknowledge timeout aborts the refill and raises an error pulse instead of hanging the core.

## Interface
- LINE_BYTES, 4, bytes per cache line; power of two, 2..16
- TIMEOUT, 15, maximum cycles mem_req may wait for mem_ack; 1..255
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- miss  in  1  cache miss request; sampled only in IDLE
- miss_addr  in  16  address that missed; sampled with miss
- busy  out  1  high whenever state is not IDLE
- mem_req  out  1  external byte read request
- mem_addr  out  16  external read address; stable while mem_req is high
- mem_ack  in  1  memory acknowledge; mem_data is valid in the same cycle
- mem_data  in  8  external read data
- fill_we  out  1  cache line write strobe, one cycle per byte
- fill_addr  out  16  cache write address
- fill_data  out  8  cache write data
- fill_done  out  1  one-cycle pulse: whole line written
- fill_err  out  1  one-cycle pulse: refill aborted on timeout

## Operation
- States: IDLE, REQ, WRITE, DONE.
- Reset (rst=1 at an edge) forces IDLE, from any state including mid-refill. All outputs are 0 in the following cycle; internal counters and address registers are cleared. No fill_done or fill_err is issued for an interrupted refill.
- IDLE -> REQ when miss=1.
  - Latch base = miss_addr with the low log2(LINE_BYTES) bits cleared.
  - Latch idx = the low bits of miss_addr.
  - Clear count and the timeout counter.
- REQ: mem_req=1, mem_addr = base | idx.
  - mem_ack=1 -> capture mem_data, go to WRITE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT -> IDLE with fill_err=1 for one cycle (registered, so it is visible in the first IDLE cycle).
- WRITE: fill_we=1, fill_addr = base | idx, fill_data = captured byte; mem_req=0.
  - If count = LINE_BYTES-1 -> DONE.
  - Otherwise idx = (idx+1) mod LINE_BYTES, count+1, clear the timeout counter, go to REQ.
- DONE: fill_done=1 for one cycle, then IDLE.
- Wrap-around: idx arithmetic is modulo LINE_BYTES. fill_addr and mem_addr never leave the line, and the upper address bits never change during a refill.
- miss while busy=1 is ignored, not queued. The cache must hold miss until it sees busy fall and fill_done.
- mem_ack while mem_req=0 is ignored.
- Each of the LINE_BYTES addresses is written exactly once per successful refill.

## Timing
- The miss is sampled at edge E0. mem_req is high in the cycle after E0.
- Zero-wait memory (mem_ack high in the first REQ cycle): each byte takes 2 cycles (REQ, WRITE).
- LINE_BYTES=4 with zero wait:
  - fill_we is high in cycles 2, 4, 6 and 8 after E0.
  - fill_done is high in cycle 9.
  - IDLE in cycle 10; a new miss can be sampled at the end of cycle 10.
- With W wait cycles per byte, each byte takes 2+W cycles.
- Timeout: with no ack, mem_req stays high for exactly TIMEOUT cycles. fill_err pulses in the next cycle, and mem_req is 0 in that cycle.
- fill_done and fill_err are never high in the same cycle. fill_we is never high in a cycle where mem_req is high.
- busy rises the cycle after miss is sampled and falls in the first IDLE cycle.

## Test plan
- Reset: hold rst=1 for 2 cycles with miss=1 -> all outputs 0, no mem_req.
- Aligned miss at 0x1230, zero-wait memory returning addr[7:0]^0xA5:
  - fill_we writes 0x1230..0x1233 in that order, with data 0x95, 0x94, 0x97, 0x96.
  - fill_done is high in cycle 9 after the sampling edge.
- Wrap miss at 0x12FE, LINE_BYTES=4:
  - mem_addr sequence is 0x12FE, 0x12FF, 0x12FC, 0x12FD; upper byte stays 0x12.
  - Exactly 4 fill_we pulses.
- Wait states: mem_ack delayed 3 cycles per byte -> mem_addr stable across each wait, each byte takes 5 cycles, fill_done follows the 4th write.
- Timeout: TIMEOUT=15, mem_ack never asserted -> mem_req high for 15 cycles, then a single fill_err pulse, no fill_we, no fill_done, busy=0.
- Mid-refill reset and overlapping miss:
  - Assert rst after the 2nd fill_we -> outputs 0 the next cycle, no fill_done.
  - A miss pulsed during an active refill -> ignored; only one line is fetched.
